// File: rtl/wb_regfile.sv
// Architectural 32 x 32-bit integer register file: write-back port, two combinational
// operand-read ports with same-cycle write-back bypass, and a req/ack debug port.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_wreg_i,
    input  logic [ADDR_W-1:0] wb_wreg_addr_i,
    input  logic [DATA_W-1:0] wb_wreg_data_i,
    input  logic              rd1_re_i,
    input  logic [ADDR_W-1:0] rd1_addr_i,
    output logic [DATA_W-1:0] rd1_data_o,
    input  logic              rd2_re_i,
    input  logic [ADDR_W-1:0] rd2_addr_i,
    output logic [DATA_W-1:0] rd2_data_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    typedef enum logic {S_IDLE, S_ACK} dbg_state_e;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    dbg_state_e        state_q, state_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              dbg_wr_acc;

    // Shared read rule for both operand ports and debug reads: x0 and disabled ports
    // read zero, and a write-back landing this cycle wins over the stored value.
    function automatic logic [DATA_W-1:0] read_mux(
        input logic              re,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wb_we,
        input logic [ADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data
    );
        if (!re || addr == '0) begin
            return '0;
        end
        if (wb_we && wb_addr == addr) begin
            return wb_data;
        end
        return stored;
    endfunction

    assign rd1_data_o = read_mux(rd1_re_i, rd1_addr_i, regs_q[rd1_addr_i],
                                 wb_wreg_i, wb_wreg_addr_i, wb_wreg_data_i);
    assign rd2_data_o = read_mux(rd2_re_i, rd2_addr_i, regs_q[rd2_addr_i],
                                 wb_wreg_i, wb_wreg_addr_i, wb_wreg_data_i);

    // Debug writes yield to write-back; reads are always accepted from IDLE.
    always_comb begin
        state_d     = state_q;
        dbg_rdata_d = dbg_rdata_q;
        dbg_wr_acc  = 1'b0;
        if (state_q == S_IDLE) begin
            if (dbg_req_i) begin
                if (!dbg_we_i) begin
                    dbg_rdata_d = read_mux(1'b1, dbg_addr_i, regs_q[dbg_addr_i],
                                           wb_wreg_i, wb_wreg_addr_i, wb_wreg_data_i);
                    state_d     = S_ACK;
                end else if (!wb_wreg_i) begin
                    dbg_wr_acc = 1'b1;
                    state_d    = S_ACK;
                end
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_wreg_i && wb_wreg_addr_i != '0) begin
            regs_d[wb_wreg_addr_i] = wb_wreg_data_i;
        end else if (dbg_wr_acc && dbg_addr_i != '0) begin
            regs_d[dbg_addr_i] = dbg_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            state_q     <= S_IDLE;
            dbg_rdata_q <= '0;
        end else begin
            regs_q      <= regs_d;
            state_q     <= state_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign dbg_ack_o   = (state_q == S_ACK);
    assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the driver pushes expected read-port values and debug
// acks from a plain array model; a negedge monitor pops and compares.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_wreg_i;
    logic [4:0]  wb_wreg_addr_i;
    logic [31:0] wb_wreg_data_i;
    logic        rd1_re_i;
    logic [4:0]  rd1_addr_i;
    logic [31:0] rd1_data_o;
    logic        rd2_re_i;
    logic [4:0]  rd2_addr_i;
    logic [31:0] rd2_data_o;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_wreg_i(wb_wreg_i), .wb_wreg_addr_i(wb_wreg_addr_i), .wb_wreg_data_i(wb_wreg_data_i),
        .rd1_re_i(rd1_re_i), .rd1_addr_i(rd1_addr_i), .rd1_data_o(rd1_data_o),
        .rd2_re_i(rd2_re_i), .rd2_addr_i(rd2_addr_i), .rd2_data_o(rd2_data_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [31:0] r1; logic [31:0] r2; } rd_exp_t;
    typedef struct { int cyc; logic [31:0] rd; } ack_exp_t;

    rd_exp_t  rdq[$];
    ack_exp_t ackq[$];
    int       n_vec = 0;
    int       n_err = 0;

    // Reference model: register contents, whether an ack is owed this cycle, last debug read.
    logic [31:0] m_regs [32];
    logic        m_busy;
    logic [31:0] m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] spec_read(input logic re, input logic [4:0] a,
                                              input logic wb, input logic [4:0] wa,
                                              input logic [31:0] wd);
        if (!re || a == 5'd0) return 32'd0;
        if (wb && wa == a) return wd;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_busy = 1'b0;
        m_last = 32'd0;
        rdq.delete();
        ackq.delete();
    endtask

    // Apply one cycle of stimulus (called just after a posedge), predict, then advance.
    task automatic drive(input logic wb, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r1e, input logic [4:0] r1a,
                         input logic r2e, input logic [4:0] r2a,
                         input logic req, input logic we, input logic [4:0] da,
                         input logic [31:0] dwd);
        rd_exp_t  e;
        ack_exp_t a;
        logic     acc;
        wb_wreg_i = wb; wb_wreg_addr_i = wa; wb_wreg_data_i = wd;
        rd1_re_i = r1e; rd1_addr_i = r1a; rd2_re_i = r2e; rd2_addr_i = r2a;
        dbg_req_i = req; dbg_we_i = we; dbg_addr_i = da; dbg_wdata_i = dwd;
        e.cyc = cyc;
        e.r1  = spec_read(r1e, r1a, wb, wa, wd);
        e.r2  = spec_read(r2e, r2a, wb, wa, wd);
        rdq.push_back(e);
        acc = !m_busy && req && (!we || !wb);
        if (acc) begin
            if (!we) m_last = spec_read(1'b1, da, wb, wa, wd);
            a.cyc = cyc + 1;
            a.rd  = m_last;
            ackq.push_back(a);
        end
        if (wb && wa != 5'd0) m_regs[wa] = wd;
        if (acc && we && da != 5'd0) m_regs[da] = dwd;
        m_busy = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        rd_exp_t  e;
        ack_exp_t a;
        if (rst_n) begin
            while (rdq.size() > 0 && rdq[0].cyc < cyc) begin
                void'(rdq.pop_front());
                n_vec++;
                n_err++;
                $display("FAIL rd_unchecked: stale expectation at cycle %0d", cyc);
            end
            if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
                e = rdq.pop_front();
                check("rd1_data", rd1_data_o, e.r1);
                check("rd2_data", rd2_data_o, e.r2);
            end
            if (ackq.size() > 0 && ackq[0].cyc == cyc) begin
                a = ackq.pop_front();
                check("dbg_ack", {31'd0, dbg_ack_o}, 32'd1);
                check("dbg_rdata", dbg_rdata_o, a.rd);
            end else begin
                check("dbg_ack_idle", {31'd0, dbg_ack_o}, 32'd0);
            end
        end
    end

    initial begin
        logic        pend, pwe;
        logic [4:0]  pa;
        logic [31:0] pd;

        rst_n = 1'b0;
        wb_wreg_i = 0; wb_wreg_addr_i = 0; wb_wreg_data_i = 0;
        rd1_re_i = 0; rd1_addr_i = 0; rd2_re_i = 0; rd2_addr_i = 0;
        dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {31'd0, dbg_ack_o}, 32'd0);
        check("reset_rdata", dbg_rdata_o, 32'd0);
        rst_n = 1'b1;

        // Write-back then read, and disabled read port.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0);

        // Bypass and x0.
        drive(1, 7, 32'h12345678, 0, 0, 1, 7, 0, 0, 0, 0);
        drive(1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 7, 0, 0, 0, 0);

        // Debug write then debug read.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 10, 32'hA5A5A5A5);
        idle();
        drive(0, 0, 0, 1, 10, 0, 0, 1, 0, 10, 0);
        idle();

        // Debug write blocked by three write-back cycles.
        for (int i = 0; i < 3; i++) drive(1, 4, 32'h100 + i, 0, 0, 0, 0, 1, 1, 3, 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 32'h1);
        drive(0, 0, 0, 1, 3, 1, 4, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);

        // Request held through acks: completions every other cycle.
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
        idle();
        idle();

        // Reset while an ack is pending.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 10, 0);
        rst_n = 1'b0;
        #1;
        check("midreset_ack", {31'd0, dbg_ack_o}, 32'd0);
        check("midreset_rdata", dbg_rdata_o, 32'd0);
        model_reset();
        wb_wreg_i = 0; rd1_re_i = 0; rd2_re_i = 0; dbg_req_i = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) drive(0, 0, 0, 1, 5'(i), 0, 0, 0, 0, 0, 0);

        // Randomized traffic with a protocol-following debug requester.
        pend = 0; pwe = 0; pa = 0; pd = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_busy) begin
                pend = 1'b0;
            end else if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                pwe  = 1'($urandom_range(0, 1));
                pa   = 5'($urandom_range(0, 31));
                pd   = $urandom;
            end
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                  pend, pwe, pa, pd);
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        if (rdq.size() != 0 || ackq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d read and %0d ack expectations left, required 0",
                     rdq.size(), ackq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
